// File: rtl/water_level_ctrl.sv
// Lock chamber water-level responder: steps the level toward 0 or MAX_LEVEL and reports busy/done/reject/fault.
// Define WATER_LEVEL_HEX_EN to enable the seven-segment decode on o_hex; otherwise o_hex is blank.
module water_level_ctrl #(
  parameter int MAX_LEVEL      = 9,
  parameter int TICKS_PER_STEP = 4,
  parameter int LW             = $clog2(MAX_LEVEL + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_inc_req,
  input  logic          i_dec_req,
  input  logic          i_gate_open,
  output logic [LW-1:0] o_level,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_reject,
  output logic          o_fault,
  output logic          o_at_low,
  output logic          o_at_high,
  output logic [6:0]    o_hex
);

  localparam int TW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_STEP - 1);
  localparam logic [LW-1:0] LEVEL_MAX = LW'(MAX_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [LW-1:0] r_level, w_level_nxt, w_level_step;
  logic [TW-1:0] r_tick, w_tick_nxt;
  logic          r_done, r_reject, r_fault;
  logic          w_done_nxt, w_reject_nxt, w_fault_nxt;
  logic          w_any_req;

  assign w_any_req    = i_inc_req | i_dec_req;
  assign w_level_step = (r_state == ST_FILL) ? (r_level + LW'(1)) : (r_level - LW'(1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_level  <= '0;
      r_tick   <= '0;
      r_done   <= 1'b0;
      r_reject <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_level  <= w_level_nxt;
      r_tick   <= w_tick_nxt;
      r_done   <= w_done_nxt;
      r_reject <= w_reject_nxt;
      r_fault  <= w_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_level_nxt  = r_level;
    w_tick_nxt   = r_tick;
    w_done_nxt   = 1'b0;
    w_reject_nxt = 1'b0;
    w_fault_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_inc_req && i_dec_req) begin
          w_reject_nxt = 1'b1;
        end else if (w_any_req && i_gate_open) begin
          w_reject_nxt = 1'b1;
        end else if (i_inc_req) begin
          if (r_level == LEVEL_MAX) begin
            w_reject_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_FILL;
            w_tick_nxt  = '0;
          end
        end else if (i_dec_req) begin
          if (r_level == '0) begin
            w_reject_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_DRAIN;
            w_tick_nxt  = '0;
          end
        end
      end
      ST_FILL, ST_DRAIN: begin
        w_reject_nxt = w_any_req;
        // A gate opening wins over a step due on the same edge.
        if (i_gate_open) begin
          w_state_nxt = ST_IDLE;
          w_fault_nxt = 1'b1;
          w_tick_nxt  = '0;
        end else if (r_tick == TICK_LAST) begin
          w_tick_nxt  = '0;
          w_level_nxt = w_level_step;
          if ((r_state == ST_FILL && w_level_step == LEVEL_MAX) ||
              (r_state == ST_DRAIN && w_level_step == '0)) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_tick_nxt = r_tick + TW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tick_nxt  = '0;
      end
    endcase
  end

  assign o_level   = r_level;
  assign o_busy    = (r_state != ST_IDLE);
  assign o_done    = r_done;
  assign o_reject  = r_reject;
  assign o_fault   = r_fault;
  assign o_at_low  = (r_level == '0);
  assign o_at_high = (r_level == LEVEL_MAX);

`ifdef WATER_LEVEL_HEX_EN
  // Segment order gfedcba, active-low.
  always_comb begin
    o_hex = 7'b1111111;
    case (r_level)
      LW'(0): o_hex = 7'b1000000;
      LW'(1): o_hex = 7'b1111001;
      LW'(2): o_hex = 7'b0100100;
      LW'(3): o_hex = 7'b0110000;
      LW'(4): o_hex = 7'b0011001;
      LW'(5): o_hex = 7'b0010010;
      LW'(6): o_hex = 7'b0000010;
      LW'(7): o_hex = 7'b1111000;
      LW'(8): o_hex = 7'b0000000;
      LW'(9): o_hex = 7'b0010000;
      default: o_hex = 7'b1111111;
    endcase
  end
`else
  assign o_hex = 7'b1111111;
`endif

endmodule

// File: tb/tb_water_level_ctrl.sv
// Self-checking bench for water_level_ctrl: directed scenarios plus random requests/gate/reset vs a behavioural model.
module tb_water_level_ctrl;
  localparam int MAX = 9;
  localparam int TPS = 4;
  localparam int LW  = $clog2(MAX + 1);

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_inc_req = 1'b0, i_dec_req = 1'b0, i_gate_open = 1'b0;
  logic [LW-1:0] o_level;
  logic          o_busy, o_done, o_reject, o_fault, o_at_low, o_at_high;
  logic [6:0]    o_hex;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: direction of travel, level, and cycles left before the next step.
  int m_dir = 0, m_level = 0, m_wait = 0;
  int m_done = 0, m_rej = 0, m_fault = 0;

  water_level_ctrl #(.MAX_LEVEL(MAX), .TICKS_PER_STEP(TPS)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_inc_req(i_inc_req), .i_dec_req(i_dec_req),
    .i_gate_open(i_gate_open), .o_level(o_level), .o_busy(o_busy), .o_done(o_done),
    .o_reject(o_reject), .o_fault(o_fault), .o_at_low(o_at_low), .o_at_high(o_at_high),
    .o_hex(o_hex)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0d exp=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_hex(input int lvl);
    logic [6:0] tab [10];
    tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
`ifdef WATER_LEVEL_HEX_EN
    return int'(tab[lvl]);
`else
    return (lvl >= 0) ? 127 : int'(tab[0]);
`endif
  endfunction

  task automatic model_reset();
    m_dir = 0; m_level = 0; m_wait = 0;
    m_done = 0; m_rej = 0; m_fault = 0;
  endtask

  task automatic model_edge(input bit inc, input bit dec, input bit gate);
    m_done = 0; m_rej = 0; m_fault = 0;
    if (m_dir == 0) begin
      if (inc || dec) begin
        if ((inc && dec) || gate || (inc && m_level == MAX) || (dec && m_level == 0))
          m_rej = 1;
        else begin
          m_dir  = inc ? 1 : -1;
          m_wait = TPS;
        end
      end
    end else begin
      if (inc || dec) m_rej = 1;
      if (gate) begin
        m_dir = 0; m_fault = 1;
      end else begin
        m_wait--;
        if (m_wait == 0) begin
          m_level += m_dir;
          m_wait = TPS;
          if ((m_dir > 0 && m_level == MAX) || (m_dir < 0 && m_level == 0)) begin
            m_dir = 0; m_done = 1;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string ctx);
    check_val({ctx, ".level"},  int'(o_level),  m_level);
    check_val({ctx, ".busy"},   int'(o_busy),   (m_dir != 0) ? 1 : 0);
    check_val({ctx, ".done"},   int'(o_done),   m_done);
    check_val({ctx, ".reject"}, int'(o_reject), m_rej);
    check_val({ctx, ".fault"},  int'(o_fault),  m_fault);
    check_val({ctx, ".at_low"}, int'(o_at_low), (m_level == 0) ? 1 : 0);
    check_val({ctx, ".at_high"},int'(o_at_high),(m_level == MAX) ? 1 : 0);
    check_val({ctx, ".hex"},    int'(o_hex),    exp_hex(m_level));
  endtask

  task automatic cycle(input bit inc, input bit dec, input bit gate, input string ctx);
    i_inc_req = inc; i_dec_req = dec; i_gate_open = gate;
    @(posedge i_clk);
    if (i_reset) model_reset();
    else model_edge(inc, dec, gate);
    #1;
    check_all(ctx);
    i_inc_req = 1'b0; i_dec_req = 1'b0;
  endtask

  task automatic run_to_level(input int target, input string ctx);
    int budget;
    budget = 0;
    while (m_level != target && budget < 200) begin
      cycle(1'b0, 1'b0, i_gate_open, ctx);
      budget++;
    end
    check_val({ctx, ".reach"}, int'(o_level), target);
  endtask

  task automatic async_reset(input string ctx);
    #2;
    i_reset = 1'b1;
    #1;
    model_reset();
    check_all(ctx);
    cycle(1'b0, 1'b0, 1'b0, {ctx, "_hold"});
    i_reset = 1'b0;
  endtask

  initial begin
    bit gate_r;
    int r;
    model_reset();
    #3;
    check_all("rst_async");
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, "idle");

    // Full fill from 0: 36 cycles after the sampling edge.
    cycle(1'b1, 1'b0, 1'b0, "fill_start");
    for (int i = 0; i < MAX * TPS; i++) cycle(1'b0, 1'b0, 1'b0, "fill");
    check_val("fill_full", int'(o_level), MAX);

    // Drain aborted by a gate at 5, then a request with the gate open.
    cycle(1'b0, 1'b1, 1'b0, "drain_start");
    run_to_level(5, "drain");
    cycle(1'b0, 1'b0, 1'b1, "gate_abort");
    cycle(1'b0, 1'b1, 1'b1, "gate_rej");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, "gate_hold");
    cycle(1'b0, 1'b0, 1'b0, "gate_close");

    // Reach level 3 via drain + gated fill, then simultaneous requests.
    cycle(1'b0, 1'b1, 1'b0, "drain2");
    run_to_level(0, "drain2");
    cycle(1'b1, 1'b0, 1'b0, "fill3");
    run_to_level(3, "fill3");
    cycle(1'b0, 1'b0, 1'b1, "abort3");
    cycle(1'b0, 1'b0, 1'b0, "abort3_close");
    cycle(1'b1, 1'b1, 1'b0, "both_req");
    cycle(1'b0, 1'b0, 1'b0, "both_after");

    // Fill to 9 and request inc at the target.
    cycle(1'b1, 1'b0, 1'b0, "fill9");
    run_to_level(MAX, "fill9");
    cycle(1'b0, 1'b0, 1'b0, "fill9_idle");
    cycle(1'b1, 1'b0, 1'b0, "inc_at_max");
    cycle(1'b0, 1'b0, 1'b0, "inc_at_max_after");

    // Request during a fill does not disturb the schedule.
    cycle(1'b0, 1'b1, 1'b0, "drain3");
    run_to_level(0, "drain3");
    cycle(1'b1, 1'b0, 1'b0, "fill_rej");
    run_to_level(2, "fill_rej");
    cycle(1'b0, 1'b1, 1'b0, "dec_in_fill");
    run_to_level(MAX, "fill_rej_end");
    cycle(1'b0, 1'b0, 1'b0, "fill_rej_idle");

    // Async reset mid-fill at level 4.
    cycle(1'b0, 1'b1, 1'b0, "drain4");
    run_to_level(0, "drain4");
    cycle(1'b1, 1'b0, 1'b0, "fill_rst");
    run_to_level(4, "fill_rst");
    async_reset("mid_rst");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, "post_rst");

    // Random traffic.
    gate_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!gate_r) gate_r = ($urandom_range(0, 59) == 0);
      else         gate_r = ($urandom_range(0, 7) != 0);
      r = $urandom_range(0, 15);
      if ($urandom_range(0, 599) == 0) async_reset("rnd_rst");
      else cycle((r == 0 || r == 2), (r == 1 || r == 2), gate_r, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/water_level_ctrl.md
# water_level_ctrl

Responder for the lock's water-level requests. It accepts single-cycle fill (`inc_req`) and drain (`dec_req`) requests from the input/debounce stage. It steps the chamber water level between 0 and `MAX_LEVEL` at a fixed rate and reports `busy`/`done`/`reject`/`fault` back to the requester. It also provides gate-permission flags to the gate logic and drives the level onto the HEX0 display.

## Interface
Parameters:
- `MAX_LEVEL`, default 9: highest water level (river-high side). Legal range 1–9.
- `TICKS_PER_STEP`, default 4: `clk` cycles per one-unit level change. Must be ≥ 1.
- `LW`, default `$clog2(MAX_LEVEL+1)`: width of the level bus.

Ports:
- `clk`  in  1: system clock (divided clock from the top level).
- `reset`  in  1: asynchronous, active-high reset.
- `inc_req`  in  1: one-cycle pulse requesting a fill to `MAX_LEVEL`.
- `dec_req`  in  1: one-cycle pulse requesting a drain to 0.
- `gate_open`  in  1: high while either gate is open.
- `level`  out  `LW`: current water level.
- `busy`  out  1: high while filling or draining.
- `done`  out  1: one-cycle pulse when the target level is reached.
- `reject`  out  1: one-cycle pulse when a request is refused.
- `fault`  out  1: one-cycle pulse when an operation is aborted by a gate opening.
- `at_low`  out  1: `level == 0`; permits the low-side gate.
- `at_high`  out  1: `level == MAX_LEVEL`; permits the high-side gate.
- `hex`  out  7: active-low seven-segment display of `level`.

## Operation
- States:
  - IDLE: no level change in progress.
  - FILL: stepping the level up toward `MAX_LEVEL`.
  - DRAIN: stepping the level down toward 0.
- IDLE transitions, evaluated at each posedge:
  - `inc_req` alone, with `!gate_open` and `level < MAX_LEVEL` → FILL; tick counter cleared.
  - `dec_req` alone, with `!gate_open` and `level > 0` → DRAIN; tick counter cleared.
  - `inc_req` and `dec_req` in the same cycle → `reject`; stay in IDLE.
  - Any request with `gate_open` high → `reject`; stay in IDLE.
  - Any request already at its target (`inc_req` at `MAX_LEVEL`, `dec_req` at 0) → `reject`; stay in IDLE.
- FILL/DRAIN stepping:
  - The tick counter counts 0..`TICKS_PER_STEP`-1.
  - On wrap, `level` changes by ±1.
  - When the new level equals the target: → IDLE, and `done` pulses.
- Any request while in FILL/DRAIN → `reject`. The operation in progress continues unaffected.
- `gate_open` rising during FILL/DRAIN → IDLE, `fault` pulses, and `level` holds its current value. This rule takes priority over a step due in the same cycle.
- `at_low`, `at_high` and `hex` are decoded combinationally from `level`.
- Arithmetic: `level` never wraps. It saturates at 0 and at `MAX_LEVEL` by construction.

## Timing
- Reset values (asynchronous):
  - state IDLE, `level` 0, tick counter 0.
  - `busy` 0, `done` 0, `reject` 0, `fault` 0.
  - `at_low` 1, `at_high` 0.
  - `hex` shows "0" (active-low 7'b1000000).
- A request is sampled at posedge E0. `busy` is high from E0 and stays high until the final step edge.
- Level changes occur at edges E0+k·`TICKS_PER_STEP`, k = 1..n.
- A full sweep takes `MAX_LEVEL`·`TICKS_PER_STEP` cycles: 36 cycles with the defaults.
- On the final step edge: `level` reaches the target, `busy` falls, and `done` rises, all on the same edge. `done` lasts exactly one cycle.
- `reject` and `fault` are registered. Each rises on the edge that samples the offending condition and lasts one cycle.
- Reset asserted mid-operation clears immediately to the reset values, including `level` = 0. No `fault` or `done` is produced.
- `TICKS_PER_STEP` = 1: the level steps on every edge after E0.

## Configuration
- `WATER_LEVEL_HEX_EN` defined: `hex` is the seven-segment decode of `level` (digits 0–9, active-low).
- `WATER_LEVEL_HEX_EN` undefined: the decoder is omitted and `hex` is tied to 7'b1111111 (all segments off).
- All other behaviour is identical with or without the macro.

## Test plan
- Reset, then idle 5 cycles → `level` 0, `at_low` 1, `busy` 0, `hex` 7'b1000000.
- `inc_req` pulse at level 0 (defaults):
  - `busy` 1 from the sampling edge; `level` steps every 4 cycles.
  - After 36 cycles: `level` 9, `at_high` 1, `busy` 0, `done` pulses once.
- At level 9, `dec_req`; then at level 5, raise `gate_open` → `fault` pulse, `level` holds 5, `busy` 0. A further `dec_req` while `gate_open` is high → `reject`, `level` still 5.
- Error cases, each producing one `reject` pulse with no state change:
  - `inc_req` and `dec_req` in the same cycle at level 3.
  - `inc_req` at level 9.
- During a fill from 0, issue `dec_req` at level 2 → `reject`; the fill continues to 9 on the original schedule.
- Assert `reset` at level 4 during a fill → `level` 0, `busy` 0 immediately, with no clock edge required. Repeat with `WATER_LEVEL_HEX_EN` undefined → `hex` stays 7'b1111111 throughout.
